pim_dma_ctrl: RTL and testbench

DMA sequencer that executes the core's DMA command (dma_en/funct3/sel_pim/size/mem_addr) by moving 32-bit words between data memory and one of four PIM units. It sits between the core's DMA interface and the dmem arbiter, acting as a bus master with a req/gnt handshake. It also drives the core's `dma_busy_i`, which holds the pipeline stalled for the whole transfer.

---
 rtl/pim_dma_ctrl_if.sv | 53 +++++
 rtl/pim_dma_ctrl.sv | 132 +++++++++++++
 tb/tb_pim_dma_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pim_dma_ctrl_if.sv
// pim_dma_ctrl_if
//   Groups the DMA command port, the dmem bus master port and the PIM unit
//   port of the PIM DMA sequencer.
//   master : sequencer view (drives busy/err, mem request, PIM strobes)
//   slave  : environment view (core command, dmem arbiter, PIM units)
interface pim_dma_ctrl_if #(
  parameter int XLEN    = 32,
  parameter int NUM_PIM = 4,
  parameter int PIM_AW  = 11
);
  // core DMA command
  logic               dma_en_i;
  logic [2:0]         dma_funct3_i;
  logic [NUM_PIM-1:0] dma_sel_pim_i;
  logic [12:0]        dma_size_i;
  logic [XLEN-1:0]    dma_mem_addr_i;
  logic               dma_busy_o;
  logic               dma_err_o;
  // dmem bus
  logic               mem_req_o;
  logic               mem_gnt_i;
  logic [XLEN-1:0]    mem_addr_o;
  logic [XLEN-1:0]    mem_wr_data_o;
  logic [XLEN-1:0]    mem_rd_data_i;
  logic [3:0]         mem_size_o;
  logic               mem_read_o;
  logic               mem_write_o;
  // PIM units
  logic [NUM_PIM-1:0] pim_sel_o;
  logic [PIM_AW-1:0]  pim_addr_o;
  logic [XLEN-1:0]    pim_wr_data_o;
  logic               pim_read_o;
  logic               pim_write_o;
  logic [XLEN-1:0]    pim_rd_data_i;

  modport master (
    input  dma_en_i, dma_funct3_i, dma_sel_pim_i, dma_size_i, dma_mem_addr_i,
    output dma_busy_o, dma_err_o,
    output mem_req_o, mem_addr_o, mem_wr_data_o, mem_size_o, mem_read_o, mem_write_o,
    input  mem_gnt_i, mem_rd_data_i,
    output pim_sel_o, pim_addr_o, pim_wr_data_o, pim_read_o, pim_write_o,
    input  pim_rd_data_i
  );

  modport slave (
    output dma_en_i, dma_funct3_i, dma_sel_pim_i, dma_size_i, dma_mem_addr_i,
    input  dma_busy_o, dma_err_o,
    input  mem_req_o, mem_addr_o, mem_wr_data_o, mem_size_o, mem_read_o, mem_write_o,
    output mem_gnt_i, mem_rd_data_i,
    input  pim_sel_o, pim_addr_o, pim_wr_data_o, pim_read_o, pim_write_o,
    output pim_rd_data_i
  );
endinterface

// File: rtl/pim_dma_ctrl.sv
// pim_dma_ctrl
//   Moves 32-bit words between data memory and one of NUM_PIM PIM units on
//   a single command from the core, one word at a time through a one-word
//   buffer (read source, capture, write destination).
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : pim_dma_ctrl_if.master (command, dmem master port, PIM port)
//
//   state | meaning
//   IDLE  | waiting for dma_en_i; the only state where commands are taken
//   SRC   | source read: mem req held until grant, or one-cycle PIM read
//   CAP   | capture source read data into the word buffer
//   DST   | destination write: one-cycle PIM write, or mem req until grant
//   DONE  | single cycle ending a command (also used for illegal / size 0)
module pim_dma_ctrl #(
  parameter int XLEN    = 32,
  parameter int NUM_PIM = 4,
  parameter int PIM_AW  = 11
) (
  input logic            clk_i,
  input logic            rst_ni,
  pim_dma_ctrl_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_SRC, S_CAP, S_DST, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_pim2mem;
  logic [NUM_PIM-1:0] r_sel;
  logic [XLEN-1:0]    r_addr;
  logic [XLEN-1:0]    r_buf;
  logic [10:0]        r_cnt;
  logic [PIM_AW-1:0]  r_idx;
  logic               r_err;

  logic w_legal, w_accept, w_last, w_dst_done;
  logic w_mem_req, w_mem_read, w_mem_write, w_pim_read, w_pim_write;

  assign w_legal = (bus.dma_funct3_i[2:1] == 2'b00) && $onehot(bus.dma_sel_pim_i) &&
                   (bus.dma_size_i[1:0] == 2'b00) && (bus.dma_mem_addr_i[1:0] == 2'b00);
  assign w_accept   = (r_state == S_IDLE) && bus.dma_en_i;
  assign w_last     = (r_cnt == 11'd1);
  // PIM writes always finish in one cycle; memory writes wait for the grant
  assign w_dst_done = (r_state == S_DST) && (!r_pim2mem || bus.mem_gnt_i);

  always_comb begin
    w_state_nxt = r_state;
    w_mem_req   = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_pim_read  = 1'b0;
    w_pim_write = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.dma_en_i) begin
          if (!w_legal || (bus.dma_size_i[12:2] == 11'd0)) w_state_nxt = S_DONE;
          else                                             w_state_nxt = S_SRC;
        end
      end
      S_SRC: begin
        if (r_pim2mem) begin
          w_pim_read  = 1'b1;
          w_state_nxt = S_CAP;
        end else begin
          w_mem_req  = 1'b1;
          w_mem_read = 1'b1;
          if (bus.mem_gnt_i) w_state_nxt = S_CAP;
        end
      end
      S_CAP: w_state_nxt = S_DST;
      S_DST: begin
        if (r_pim2mem) begin
          w_mem_req   = 1'b1;
          w_mem_write = 1'b1;
        end else begin
          w_pim_write = 1'b1;
        end
        if (w_dst_done) w_state_nxt = w_last ? S_DONE : S_SRC;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_pim2mem <= 1'b0;
      r_sel     <= '0;
      r_addr    <= '0;
      r_buf     <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_err <= !w_legal;
        // illegal commands leave the datapath untouched so outputs stay quiet
        if (w_legal) begin
          r_pim2mem <= bus.dma_funct3_i[0];
          r_sel     <= bus.dma_sel_pim_i;
          r_addr    <= bus.dma_mem_addr_i;
          r_cnt     <= bus.dma_size_i[12:2];
          r_idx     <= '0;
        end
      end
      if (r_state == S_CAP) r_buf <= r_pim2mem ? bus.pim_rd_data_i : bus.mem_rd_data_i;
      if (w_dst_done) begin
        r_addr <= r_addr + XLEN'(4);
        r_cnt  <= r_cnt - 11'd1;
        // hold the index on the last word so it never passes 2046
        if (!w_last) r_idx <= r_idx + PIM_AW'(1);
      end
    end
  end

  assign bus.dma_busy_o    = (r_state != S_IDLE);
  assign bus.dma_err_o     = r_err;
  assign bus.mem_req_o     = w_mem_req;
  assign bus.mem_read_o    = w_mem_read;
  assign bus.mem_write_o   = w_mem_write;
  assign bus.mem_size_o    = {4{w_mem_req}};
  assign bus.mem_addr_o    = r_addr;
  assign bus.mem_wr_data_o = r_buf;
  assign bus.pim_read_o    = w_pim_read;
  assign bus.pim_write_o   = w_pim_write;
  assign bus.pim_sel_o     = (w_pim_read || w_pim_write) ? r_sel : '0;
  assign bus.pim_addr_o    = r_idx;
  assign bus.pim_wr_data_o = r_buf;

endmodule

// File: tb/tb_pim_dma_ctrl.sv
// tb_pim_dma_ctrl
//   Directed bench for pim_dma_ctrl. A negedge monitor plays dmem arbiter
//   and PIM unit (memory read data = addr ^ 0xA5A5_0000, PIM read data =
//   0xBEEF_0000 | index) and logs every completed transfer and strobe.
module tb_pim_dma_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pim_dma_ctrl_if bus ();
  pim_dma_ctrl dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] m_addr[$];
  logic [31:0] m_data[$];
  logic        m_wr[$];
  logic [3:0]  m_sz[$];
  logic [31:0] p_idx[$];
  logic [31:0] p_data[$];
  logic [3:0]  p_sel[$];
  int          pr_n, busy_cnt, req_cyc, wait_left, stall_cyc;
  logic [3:0]  pr_sel;
  bit          stall_started, stall_closed, stall_bad;
  logic [31:0] st_addr, st_data;

  task automatic clear_logs();
    m_addr.delete(); m_data.delete(); m_wr.delete(); m_sz.delete();
    p_idx.delete(); p_data.delete(); p_sel.delete();
    pr_n = 0; busy_cnt = 0; req_cyc = 0; stall_cyc = 0; pr_sel = '0;
    stall_started = 0; stall_closed = 0; stall_bad = 0;
  endtask

  always @(negedge clk) begin
    if (bus.dma_busy_o) busy_cnt++;
    if (bus.mem_req_o) req_cyc++;
    if (bus.mem_req_o && bus.mem_write_o && wait_left > 0) begin
      bus.mem_gnt_i = 1'b0;
      wait_left--;
      stall_cyc++;
      if (!stall_started) begin
        st_addr = bus.mem_addr_o;
        st_data = bus.mem_wr_data_o;
        stall_started = 1;
      end else if (bus.mem_addr_o !== st_addr || bus.mem_wr_data_o !== st_data) begin
        stall_bad = 1;
      end
    end else begin
      bus.mem_gnt_i = 1'b1;
    end
    if (bus.mem_req_o && bus.mem_gnt_i) begin
      if (stall_started && !stall_closed) begin
        if (bus.mem_addr_o !== st_addr || bus.mem_wr_data_o !== st_data) stall_bad = 1;
        stall_closed = 1;
      end
      m_addr.push_back(bus.mem_addr_o);
      m_data.push_back(bus.mem_wr_data_o);
      m_wr.push_back(bus.mem_write_o);
      m_sz.push_back(bus.mem_size_o);
      if (bus.mem_read_o) bus.mem_rd_data_i = bus.mem_addr_o ^ 32'hA5A5_0000;
    end
    if (bus.pim_read_o) begin
      pr_n++;
      pr_sel = bus.pim_sel_o;
      bus.pim_rd_data_i = 32'hBEEF_0000 | 32'(bus.pim_addr_o);
    end
    if (bus.pim_write_o) begin
      p_idx.push_back(32'(bus.pim_addr_o));
      p_data.push_back(bus.pim_wr_data_o);
      p_sel.push_back(bus.pim_sel_o);
    end
  end

  // Issues one command pulse at a negedge and waits (bounded) for busy to drop.
  // inject_at >= 0 fires a second, different pulse that many cycles into busy.
  task automatic run_cmd(input logic [2:0] f3, input logic [3:0] sel, input logic [12:0] size,
                         input logic [31:0] addr, input int inject_at);
    int cyc;
    bus.dma_funct3_i   = f3;
    bus.dma_sel_pim_i  = sel;
    bus.dma_size_i     = size;
    bus.dma_mem_addr_i = addr;
    bus.dma_en_i       = 1'b1;
    @(negedge clk);
    bus.dma_en_i = 1'b0;
    check_val("busy_rise", 32'(bus.dma_busy_o), 32'd1);
    cyc = 0;
    while (bus.dma_busy_o && cyc < 200) begin
      if (cyc == inject_at) begin
        bus.dma_funct3_i   = 3'b001;
        bus.dma_sel_pim_i  = 4'b0001;
        bus.dma_size_i     = 13'd40;
        bus.dma_mem_addr_i = 32'h0000_0040;
        bus.dma_en_i       = 1'b1;
      end
      @(negedge clk);
      bus.dma_en_i = 1'b0;
      cyc++;
    end
    check_val("busy_fall_in_budget", 32'(bus.dma_busy_o), 32'd0);
  endtask

  logic [31:0] exp_a[3];
  logic [2:0]  il_f3[4];
  logic [3:0]  il_sel[4];
  logic [12:0] il_size[4];
  logic [31:0] il_addr[4];
  int          k;

  initial begin
    bus.dma_en_i = 0; bus.dma_funct3_i = 0; bus.dma_sel_pim_i = 0;
    bus.dma_size_i = 0; bus.dma_mem_addr_i = 0; bus.mem_gnt_i = 1;
    bus.mem_rd_data_i = 0; bus.pim_rd_data_i = 0;
    wait_left = 0;
    clear_logs();

    // reset values
    repeat (2) @(negedge clk);
    check_val("rst_busy_err", {30'd0, bus.dma_busy_o, bus.dma_err_o}, 32'd0);
    check_val("rst_mem_ctl", {26'd0, bus.mem_req_o, bus.mem_read_o, bus.mem_write_o, bus.mem_size_o[2:0]}, 32'd0);
    check_val("rst_pim_ctl", {26'd0, bus.pim_read_o, bus.pim_write_o, bus.pim_sel_o}, 32'd0);
    check_val("rst_mem_addr", bus.mem_addr_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MEM->PIM, 3 words, zero-wait grant
    clear_logs();
    run_cmd(3'b000, 4'b0010, 13'd12, 32'h2000_0000, -1);
    check_val("t1_busy_cycles", busy_cnt, 32'd10);
    check_val("t1_err", 32'(bus.dma_err_o), 32'd0);
    check_val("t1_mem_n", m_addr.size(), 32'd3);
    check_val("t1_pim_n", p_idx.size(), 32'd3);
    exp_a[0] = 32'h85A5_0000; exp_a[1] = 32'h85A5_0004; exp_a[2] = 32'h85A5_0008;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("t1_rd_addr%0d", i), m_addr[i], 32'h2000_0000 + 32'(4 * i));
      check_val($sformatf("t1_rd_dir%0d", i), 32'(m_wr[i]), 32'd0);
      check_val($sformatf("t1_pim_idx%0d", i), p_idx[i], 32'(i));
      check_val($sformatf("t1_pim_sel%0d", i), 32'(p_sel[i]), 32'h2);
      check_val($sformatf("t1_pim_data%0d", i), p_data[i], exp_a[i]);
    end

    // PIM->MEM, 2 words, 3 wait cycles on the first write
    clear_logs();
    wait_left = 3;
    run_cmd(3'b001, 4'b1000, 13'd8, 32'h3000_0100, -1);
    check_val("t2_busy_cycles", busy_cnt, 32'd10);
    check_val("t2_pim_reads", pr_n, 32'd2);
    check_val("t2_pim_rd_sel", 32'(pr_sel), 32'h8);
    check_val("t2_pim_writes", p_idx.size(), 32'd0);
    check_val("t2_stall_cycles", stall_cyc, 32'd3);
    check_val("t2_stall_stable", 32'(stall_bad), 32'd0);
    check_val("t2_mem_n", m_addr.size(), 32'd2);
    check_val("t2_wr_addr0", m_addr[0], 32'h3000_0100);
    check_val("t2_wr_addr1", m_addr[1], 32'h3000_0104);
    check_val("t2_wr_data0", m_data[0], 32'hBEEF_0000);
    check_val("t2_wr_data1", m_data[1], 32'hBEEF_0001);
    check_val("t2_wr_dir", {30'd0, m_wr[0], m_wr[1]}, 32'd3);
    check_val("t2_wr_size", {m_sz[0], m_sz[1]}, 32'hFF);

    // illegal commands
    il_f3[0] = 3'b010; il_sel[0] = 4'b0001; il_size[0] = 13'd8; il_addr[0] = 32'h1000;
    il_f3[1] = 3'b000; il_sel[1] = 4'b0011; il_size[1] = 13'd8; il_addr[1] = 32'h1000;
    il_f3[2] = 3'b000; il_sel[2] = 4'b0001; il_size[2] = 13'd6; il_addr[2] = 32'h1000;
    il_f3[3] = 3'b000; il_sel[3] = 4'b0001; il_size[3] = 13'd8; il_addr[3] = 32'h1002;
    for (k = 0; k < 4; k++) begin
      clear_logs();
      run_cmd(il_f3[k], il_sel[k], il_size[k], il_addr[k], -1);
      check_val($sformatf("ill%0d_err", k), 32'(bus.dma_err_o), 32'd1);
      check_val($sformatf("ill%0d_busy", k), busy_cnt, 32'd1);
      check_val($sformatf("ill%0d_req", k), req_cyc, 32'd0);
      check_val($sformatf("ill%0d_pim", k), pr_n + p_idx.size(), 32'd0);
    end

    // size 0 (legal) clears err
    clear_logs();
    run_cmd(3'b000, 4'b0100, 13'd0, 32'h0000_1000, -1);
    check_val("sz0_err", 32'(bus.dma_err_o), 32'd0);
    check_val("sz0_busy", busy_cnt, 32'd1);
    check_val("sz0_req", req_cyc, 32'd0);
    check_val("sz0_pim", pr_n + p_idx.size(), 32'd0);

    // address wrap, second pulse mid-transfer ignored
    clear_logs();
    run_cmd(3'b000, 4'b0001, 13'd8, 32'hFFFF_FFFC, 2);
    check_val("wrap_busy", busy_cnt, 32'd7);
    check_val("wrap_mem_n", m_addr.size(), 32'd2);
    check_val("wrap_addr0", m_addr[0], 32'hFFFF_FFFC);
    check_val("wrap_addr1", m_addr[1], 32'h0000_0000);
    check_val("wrap_pdata0", p_data[0], 32'h5A5A_FFFC);
    check_val("wrap_pdata1", p_data[1], 32'hA5A5_0000);
    check_val("wrap_err", 32'(bus.dma_err_o), 32'd0);
    @(negedge clk);
    check_val("wrap_no_restart", 32'(bus.dma_busy_o), 32'd0);

    // reset during DST of word 1 of a PIM->MEM transfer
    clear_logs();
    bus.dma_funct3_i = 3'b001; bus.dma_sel_pim_i = 4'b0001;
    bus.dma_size_i = 13'd8; bus.dma_mem_addr_i = 32'h0000_0100;
    bus.dma_en_i = 1'b1;
    @(negedge clk);
    bus.dma_en_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_write_o && bus.pim_addr_o == 11'd1) break;
      @(negedge clk);
    end
    check_val("rstx_reached_dst1", {31'd0, bus.mem_write_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rstx_busy_err", {30'd0, bus.dma_busy_o, bus.dma_err_o}, 32'd0);
    check_val("rstx_mem_ctl", {24'd0, bus.mem_req_o, bus.mem_read_o, bus.mem_write_o, 1'b0, bus.mem_size_o}, 32'd0);
    check_val("rstx_pim_ctl", {26'd0, bus.pim_read_o, bus.pim_write_o, bus.pim_sel_o}, 32'd0);
    check_val("rstx_mem_addr", bus.mem_addr_o, 32'd0);
    check_val("rstx_mem_wdata", bus.mem_wr_data_o, 32'd0);
    check_val("rstx_pim_addr", 32'(bus.pim_addr_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rstx_idle", 32'(bus.dma_busy_o), 32'd0);
    clear_logs();
    run_cmd(3'b000, 4'b0001, 13'd4, 32'h0000_0040, -1);
    check_val("post_busy", busy_cnt, 32'd4);
    check_val("post_mem_n", m_addr.size(), 32'd1);
    check_val("post_addr", m_addr[0], 32'h0000_0040);
    check_val("post_pim_idx", p_idx[0], 32'd0);
    check_val("post_pim_data", p_data[0], 32'hA5A5_0040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
